// File: rtl/broadsync_pkg.sv
// Shared types and constants for the BroadSync slave-side servo.
package broadsync_pkg;

   localparam int unsigned NS_PER_SEC = 1_000_000_000;
   localparam int unsigned TIME_W     = 80;
   localparam int unsigned SEC_W      = 48;
   localparam int unsigned NS_W       = 32;

   typedef enum logic [1:0] {
      StFree     = 2'd0,
      StAcquire  = 2'd1,
      StTrack    = 2'd2,
      StHoldover = 2'd3
   } servo_state_e;

endpackage

// File: rtl/broadsync_offset_calc.sv
// Front half of the servo pipeline: capture the time pair, subtract, then
// fold a +/-1 s difference into a nanosecond offset and classify it.
module broadsync_offset_calc
   import broadsync_pkg::*;
#(
   parameter int unsigned STEP_THRESHOLD_NS = 1000
) (
   input  logic                   ptp_clk,
   input  logic                   ptp_reset_n,
   input  logic                   in_valid,
   input  logic [TIME_W-1:0]      rx_time,
   input  logic [TIME_W-1:0]      local_time,
   output logic                   busy,
   output logic                   out_valid,
   output logic signed [NS_W+1:0] off,
   output logic [SEC_W-1:0]       sec_diff,
   output logic [NS_W-1:0]        ns_diff,
   output logic                   is_big,
   output logic                   is_wide
);

   localparam logic signed [NS_W+1:0] NsPerSec  = (NS_W + 2)'(NS_PER_SEC);
   localparam logic [NS_W+1:0]        Threshold = (NS_W + 2)'(STEP_THRESHOLD_NS);

   logic                   v0_q, v1_q;
   logic [TIME_W-1:0]      rx_q, loc_q;
   logic signed [SEC_W:0]  sec_diff_d, sec_diff_q;
   logic signed [NS_W:0]   ns_diff_d, ns_diff_q;
   logic signed [NS_W+1:0] ns_ext, off_c;
   logic [NS_W+1:0]        abs_off;
   logic                   sec_zero, sec_pos1, sec_neg1;

   // Zero-extend before subtracting so the difference is a true signed value.
   assign sec_diff_d = $signed({1'b0, rx_q[TIME_W-1:NS_W]}) - $signed({1'b0, loc_q[TIME_W-1:NS_W]});
   assign ns_diff_d  = $signed({1'b0, rx_q[NS_W-1:0]}) - $signed({1'b0, loc_q[NS_W-1:0]});

   always_ff @(posedge ptp_clk or negedge ptp_reset_n) begin
      if (!ptp_reset_n) begin
         v0_q       <= 1'b0;
         v1_q       <= 1'b0;
         rx_q       <= '0;
         loc_q      <= '0;
         sec_diff_q <= '0;
         ns_diff_q  <= '0;
      end else begin
         v0_q <= in_valid;
         v1_q <= v0_q;
         if (in_valid) begin
            rx_q  <= rx_time;
            loc_q <= local_time;
         end
         if (v0_q) begin
            sec_diff_q <= sec_diff_d;
            ns_diff_q  <= ns_diff_d;
         end
      end
   end

   always_comb begin
      sec_zero = (sec_diff_q == '0);
      sec_pos1 = (sec_diff_q == (SEC_W + 1)'(1));
      sec_neg1 = (sec_diff_q == '1);
      ns_ext   = (NS_W + 2)'(ns_diff_q);
      off_c    = ns_ext;
      if (sec_pos1) begin
         off_c = ns_ext + NsPerSec;
      end else if (sec_neg1) begin
         off_c = ns_ext - NsPerSec;
      end
      abs_off = off_c[NS_W+1] ? -off_c : off_c;
      is_wide = !(sec_zero || sec_pos1 || sec_neg1);
      is_big  = is_wide || (abs_off > Threshold);
   end

   assign busy      = v0_q | v1_q;
   assign out_valid = v1_q;
   assign off       = off_c;
   assign sec_diff  = sec_diff_q[SEC_W-1:0];
   assign ns_diff   = ns_diff_q[NS_W-1:0];

endmodule

// File: rtl/broadsync_servo.sv
// Slave-side time servo: turns decoded BroadSync frames into step corrections
// and a saturating drift word for the GTM, with acquire/track/holdover states.
module broadsync_servo
   import broadsync_pkg::*;
#(
   parameter int unsigned STEP_THRESHOLD_NS = 1000,
   parameter int unsigned LOCK_COUNT        = 4,
   parameter int unsigned KI_SHIFT          = 4,
   parameter int unsigned TIMEOUT_CYCLES    = 250000000,
   parameter int unsigned HOLDOVER_TIMEOUTS = 8
) (
   input  logic                ptp_clk,
   input  logic                ptp_reset_n,
   input  logic                frame_valid,
   input  logic                rx_frame_error,
   input  logic                rx_lock,
   input  logic [TIME_W-1:0]   rx_time,
   input  logic [TIME_W-1:0]   local_time,
   output logic                step_valid,
   output logic signed [47:0]  step_sec,
   output logic signed [31:0]  step_ns,
   output logic signed [30:0]  drift_rate,
   output logic [1:0]          servo_state,
   output logic                locked,
   output logic signed [31:0]  last_offset_ns,
   output logic [15:0]         error_count,
   output logic [15:0]         drop_count
);

   localparam logic signed [30:0] DriftPos = 31'sh3FFF_FFFF;
   localparam logic signed [30:0] DriftNeg = -DriftPos;
   localparam logic [31:0]        TmoLast  = 32'(TIMEOUT_CYCLES - 1);

   logic                   good, busy, calc_valid, is_big, is_wide, tmo_evt, apply_drift;
   logic signed [NS_W+1:0] off, off_shr;
   logic [SEC_W-1:0]       sec_diff;
   logic [NS_W-1:0]        ns_diff;
   logic signed [34:0]     drift_sum;
   logic signed [30:0]     drift_sat;
   logic [15:0]            lock_inc, hold_inc;

   servo_state_e       state_q, state_d;
   logic [15:0]        lock_cnt_q, lock_cnt_d, hold_cnt_q, hold_cnt_d;
   logic [15:0]        err_q, err_d, drop_q, drop_d;
   logic [31:0]        tmo_q, tmo_d;
   logic signed [30:0] drift_q, drift_d;
   logic               step_valid_q, step_valid_d, locked_q, locked_d;
   logic [47:0]        step_sec_q, step_sec_d;
   logic [31:0]        step_ns_q, step_ns_d, last_off_q, last_off_d;

   assign good = frame_valid & ~rx_frame_error & rx_lock;

   broadsync_offset_calc #(
      .STEP_THRESHOLD_NS (STEP_THRESHOLD_NS)
   ) u_offset_calc (
      .ptp_clk     (ptp_clk),
      .ptp_reset_n (ptp_reset_n),
      .in_valid    (good & ~busy),
      .rx_time     (rx_time),
      .local_time  (local_time),
      .busy        (busy),
      .out_valid   (calc_valid),
      .off         (off),
      .sec_diff    (sec_diff),
      .ns_diff     (ns_diff),
      .is_big      (is_big),
      .is_wide     (is_wide)
   );

   assign off_shr   = off >>> KI_SHIFT;
   assign drift_sum = 35'(drift_q) + 35'(off_shr);
   assign drift_sat = (drift_sum > 35'(DriftPos)) ? DriftPos :
                      (drift_sum < 35'(DriftNeg)) ? DriftNeg : drift_sum[30:0];
   assign lock_inc  = lock_cnt_q + 16'd1;
   assign hold_inc  = hold_cnt_q + 16'd1;
   // A frame landing in C3 clears the timer, so it also suppresses the timeout.
   assign tmo_evt   = ~calc_valid & (tmo_q == TmoLast);

   always_comb begin
      state_d      = state_q;
      lock_cnt_d   = lock_cnt_q;
      hold_cnt_d   = hold_cnt_q;
      drift_d      = drift_q;
      step_valid_d = 1'b0;
      step_sec_d   = step_sec_q;
      step_ns_d    = step_ns_q;
      last_off_d   = last_off_q;
      err_d        = err_q;
      drop_d       = drop_q;
      apply_drift  = 1'b0;
      tmo_d        = (calc_valid || tmo_evt) ? 32'd0 : tmo_q + 32'd1;

      if (frame_valid && rx_frame_error && (err_q != 16'hFFFF)) err_d = err_q + 16'd1;
      if (good && busy && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;

      if (calc_valid) begin
         if (is_big) begin
            step_valid_d = 1'b1;
            step_sec_d   = is_wide ? sec_diff : 48'd0;
            step_ns_d    = is_wide ? ns_diff : off[31:0];
            state_d      = StAcquire;
            lock_cnt_d   = '0;
            hold_cnt_d   = '0;
         end else begin
            unique case (state_q)
               StFree: begin
                  state_d    = StAcquire;
                  lock_cnt_d = 16'd1;
               end
               StAcquire: begin
                  apply_drift = 1'b1;
                  lock_cnt_d  = lock_inc;
                  if (lock_inc >= 16'(LOCK_COUNT)) state_d = StTrack;
               end
               StTrack: apply_drift = 1'b1;
               StHoldover: begin
                  apply_drift = 1'b1;
                  state_d     = StTrack;
                  hold_cnt_d  = '0;
               end
            endcase
         end
      end else if (tmo_evt) begin
         case (state_q)
            StAcquire: begin
               state_d    = StFree;
               drift_d    = '0;
               lock_cnt_d = '0;
            end
            StTrack: begin
               state_d    = StHoldover;
               hold_cnt_d = 16'd1;
            end
            StHoldover: begin
               hold_cnt_d = hold_inc;
               if (hold_inc >= 16'(HOLDOVER_TIMEOUTS)) begin
                  state_d    = StFree;
                  drift_d    = '0;
                  hold_cnt_d = '0;
               end
            end
            default: ;
         endcase
      end

      if (apply_drift) begin
         drift_d    = drift_sat;
         last_off_d = off[31:0];
      end
      locked_d = (state_d == StTrack);
   end

   always_ff @(posedge ptp_clk or negedge ptp_reset_n) begin
      if (!ptp_reset_n) begin
         state_q      <= StFree;
         lock_cnt_q   <= '0;
         hold_cnt_q   <= '0;
         drift_q      <= '0;
         step_valid_q <= 1'b0;
         step_sec_q   <= '0;
         step_ns_q    <= '0;
         last_off_q   <= '0;
         err_q        <= '0;
         drop_q       <= '0;
         tmo_q        <= '0;
         locked_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         lock_cnt_q   <= lock_cnt_d;
         hold_cnt_q   <= hold_cnt_d;
         drift_q      <= drift_d;
         step_valid_q <= step_valid_d;
         step_sec_q   <= step_sec_d;
         step_ns_q    <= step_ns_d;
         last_off_q   <= last_off_d;
         err_q        <= err_d;
         drop_q       <= drop_d;
         tmo_q        <= tmo_d;
         locked_q     <= locked_d;
      end
   end

   assign step_valid     = step_valid_q;
   assign step_sec       = step_sec_q;
   assign step_ns        = step_ns_q;
   assign drift_rate     = drift_q;
   assign servo_state    = state_q;
   assign locked         = locked_q;
   assign last_offset_ns = last_off_q;
   assign error_count    = err_q;
   assign drop_count     = drop_q;

endmodule

// File: doc/broadsync_servo.md
Name: broadsync_servo

Overview:
- Downstream consumer of the BroadSync slave's decoded frames.
- Each accepted frame carries a received time-of-day. The block compares it with the local GTM time captured on the same cycle and computes a signed offset.
- It runs an acquire/track/holdover state machine. Large offsets produce one-shot step corrections; small offsets are integrated into a saturating drift-rate word.
- Its outputs feed the GTM's offset and drift inputs, closing the slave-side time-sync loop.

Parameters:
- STEP_THRESHOLD_NS, 1000: offset magnitude in ns above which a step is issued instead of a drift update.
- LOCK_COUNT, 4: consecutive small-offset frames needed in ACQUIRE to enter TRACK.
- KI_SHIFT, 4: arithmetic right shift applied to the offset before it is added to drift_rate.
- TIMEOUT_CYCLES, 250000000: ptp_clk cycles without a good frame before a timeout event.
- HOLDOVER_TIMEOUTS, 8: consecutive timeout events tolerated in HOLDOVER before falling to FREE.

Ports:
- ptp_clk  in  1  single clock.
- ptp_reset_n  in  1  asynchronous, active-low reset.
- frame_valid  in  1  one-cycle strobe: slave frame update complete.
- rx_frame_error  in  1  qualifies frame_valid; 1 = CRC failure.
- rx_lock  in  1  lock bit carried in the frame.
- rx_time  in  80  received time {seconds[79:32], nanoseconds[31:0]}.
- local_time  in  80  GTM sync_time, same format.
- step_valid  out  1  one-cycle strobe: apply step_sec/step_ns.
- step_sec  out  48  signed seconds correction.
- step_ns  out  32  signed nanoseconds correction.
- drift_rate  out  31  signed drift word to the GTM.
- servo_state  out  2  0 FREE, 1 ACQUIRE, 2 TRACK, 3 HOLDOVER.
- locked  out  1  high iff servo_state==TRACK.
- last_offset_ns  out  32  signed offset of the last small-offset frame.
- error_count  out  16  saturating count of rx_frame_error frames.
- drop_count  out  16  saturating count of frames dropped while the pipeline is busy.

Behaviour:
- Reset (async, ptp_reset_n=0):
  - All outputs 0; servo_state = FREE.
  - Pipeline, timeout counter and holdover counter cleared.
  - Applies immediately, including mid-pipeline; any in-flight frame is discarded.
- Frame acceptance:
  - A good frame is frame_valid & ~rx_frame_error & rx_lock.
  - frame_valid & rx_frame_error: increments error_count (saturates at 16'hFFFF). No other effect.
  - frame_valid & ~rx_frame_error & ~rx_lock: ignored entirely.
- Pipeline, latency 3 cycles from a good frame_valid (cycle 0) to the step_valid/drift_rate/state update (cycle 3):
  - C0: register rx_time and local_time.
  - C1: sec_diff = rx_sec - local_sec (49-bit signed); ns_diff = rx_ns - local_ns (33-bit signed).
  - C2: classify and normalise:
    - sec_diff==0: off = ns_diff.
    - sec_diff==+1: off = ns_diff + 1e9.
    - sec_diff==-1: off = ns_diff - 1e9.
    - otherwise: the frame is "big".
    - Also big when |off| > STEP_THRESHOLD_NS.
  - C3: apply the state machine.
  - A good frame arriving while C0–C2 is occupied is dropped and increments drop_count (saturating).
- Step outputs:
  - On a big frame, step_valid pulses for 1 cycle.
  - If |sec_diff|>1: step_sec = sec_diff[47:0], step_ns = ns_diff[31:0].
  - Otherwise: step_sec = 0, step_ns = off.
  - step_sec/step_ns hold their value until the next step.
- Drift update (small frame, not in FREE):
  - drift_rate <= sat31(drift_rate + (off >>> KI_SHIFT)).
  - Saturation limits are ±(2^30-1).
  - last_offset_ns <= off.
- Timeout:
  - A 32-bit counter is cleared by every good frame that reaches C3. Otherwise it increments.
  - At TIMEOUT_CYCLES-1 it raises a one-cycle timeout event and restarts from 0.
  - If a good frame's C3 and a timeout fall in the same cycle, the frame wins and no timeout is counted.
- State machine (a step always clears the lock counter):
  - FREE: drift_rate held at 0. Big frame → step, go ACQUIRE with cnt=0. Small frame → ACQUIRE with cnt=1, no drift update.
  - ACQUIRE:
    - Small frame → drift update, cnt+1; when cnt reaches LOCK_COUNT → TRACK.
    - Big frame → step, cnt=0.
    - Timeout → FREE, drift_rate=0.
  - TRACK: small frame → drift update. Big frame → step, go ACQUIRE with cnt=0. Timeout → HOLDOVER with hcnt=1.
  - HOLDOVER: drift_rate frozen.
    - Small frame → drift update, go TRACK.
    - Big frame → step, go ACQUIRE.
    - Timeout → hcnt+1; at HOLDOVER_TIMEOUTS → FREE, drift_rate=0.
- locked and servo_state are registered and update in C3 / on the timeout cycle.

Decomposition:
- Shared package broadsync_pkg holds:
  - the servo_state enum (FREE/ACQUIRE/TRACK/HOLDOVER);
  - NS_PER_SEC = 1_000_000_000;
  - TIME_W = 80, SEC_W = 48, NS_W = 32.
- One sub-module, broadsync_offset_calc, holds pipeline C0–C2: it takes the time pair and produces off, sec_diff, ns_diff and is_big with a valid flag. The state machine, counters and saturation stay in broadsync_servo.

Test Plan (sim params: TIMEOUT_CYCLES=100, LOCK_COUNT=3, STEP_THRESHOLD_NS=1000, KI_SHIFT=2, HOLDOVER_TIMEOUTS=2):
- Good frame with rx_time={5,999_999_900}, local_time={6,100}, from FREE → off=-200, no step, ACQUIRE, drift_rate stays 0; second identical frame → drift_rate=-50.
- Good frame with rx={10,0}, local={7,500} → 3 cycles later step_valid=1, step_sec=3, step_ns=-500, state ACQUIRE.
- Three consecutive frames with off=+400 from FREE → ACQUIRE then TRACK; locked=1; drift_rate=+200 (two updates of +100).
- In TRACK, no frames for 100 cycles → HOLDOVER; another 100 cycles → hcnt=2 → FREE, drift_rate=0, locked=0.
- frame_valid with rx_frame_error=1 ×3 → error_count=3, state unchanged. Good frame followed one cycle later by a second good frame → drop_count=1.
- Assert ptp_reset_n=0 in cycle C1 of a big frame → no step_valid; all outputs 0 immediately; FREE after release.
- Drift preload near +2^30-1, then a frame with off=+1000 → drift_rate saturates at 1073741823.
